// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encodings,
// access-size codes, the IO address prefix and the latched request record.
package mem_ctrl_pkg;

    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;
    localparam logic [31:0] ZERO32 = 32'h0000_0000;

    // addr[17:16] value that selects the hci IO window
    localparam logic [1:0] IO_PREFIX = 2'b11;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_READ  = 2'd1,
        STATE_WRITE = 2'd2,
        STATE_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSB = 1'b1
    } owner_e;

    // Request captured at grant; the requester's inputs are not looked at again.
    typedef struct packed {
        owner_e          owner;
        logic [2:0]      len;    // byte count 1/2/4
        logic [3:0][7:0] data;   // store data, byte lane k goes out in byte cycle k
    } req_t;

    // Size code to byte count; the illegal code 11 behaves as a word.
    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester-side bundle of the memory controller: the IF fetch channel and
// the LSB load/store channel.
//   master : driven by IF/LSB (valid, address, size, store data)
//   slave  : the memory controller (returns data word and done pulse)
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              IF_valid_in;
    logic [ADDR_W-1:0] IF_addr_in;
    logic [31:0]       IF_data_out;
    logic              IF_done_out;

    logic              LSB_valid_in;
    logic              LSB_wr_in;
    logic [1:0]        LSB_size_in;
    logic [ADDR_W-1:0] LSB_addr_in;
    logic [31:0]       LSB_data_in;
    logic [31:0]       LSB_data_out;
    logic              LSB_done_out;

    modport master (
        output IF_valid_in, IF_addr_in,
        output LSB_valid_in, LSB_wr_in, LSB_size_in, LSB_addr_in, LSB_data_in,
        input  IF_data_out, IF_done_out, LSB_data_out, LSB_done_out
    );

    modport slave (
        input  IF_valid_in, IF_addr_in,
        input  LSB_valid_in, LSB_wr_in, LSB_size_in, LSB_addr_in, LSB_data_in,
        output IF_data_out, IF_done_out, LSB_data_out, LSB_done_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: single owner of the byte-wide RAM/IO port.
// Arbitrates IF fetches (4 bytes) and LSB loads/stores (1/2/4 bytes),
// serialises each into byte cycles and returns a little-endian,
// zero-extended word with a one-cycle done pulse.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rdy              global enable, low freezes the controller
//   jump_wrong       misprediction flush (aborts reads, stores complete)
//   io_buffer_full   hci output full, stalls IO-window store bytes
//   mem_din/mem_dout RAM read/write byte
//   mem_a, mem_wr    RAM byte address and write strobe
//   bus              requester channels (mem_ctrl_if.slave)
module mem_ctrl #(
    parameter int         ADDR_W    = 32,
    parameter logic [1:0] IO_PREFIX = mem_ctrl_pkg::IO_PREFIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    mem_ctrl_if.slave         bus
);
    import mem_ctrl_pkg::*;

    state_e          state_q, state_d;
    owner_e          last_grant;
    req_t            req_q;
    logic [2:0]      cnt_q;       // index of the byte currently on mem_a
    logic [3:0][7:0] buf_q;       // read assembly buffer
    logic [31:0]     if_data_q, lsb_data_q;
    logic            grant, grant_if;
    logic            stall;
    logic [1:0]      lane;
    logic [7:0]      din_eff;
    logic [3:0][7:0] asm_word;

    // The RAM keeps answering while the core is frozen, so the byte that was
    // in flight when rdy fell shows up during the first frozen cycle. Capture
    // it there and use it in place of mem_din on the resume cycle. These two
    // follow the RAM port, not the core, and so run regardless of rdy.
    logic       rdy_q;
    logic [7:0] din_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q    <= TRUE;
            din_hold <= 8'h00;
        end else begin
            rdy_q <= rdy;
            if (rdy_q && !rdy) din_hold <= mem_din;
        end
    end

    assign din_eff = rdy_q ? mem_din : din_hold;
    assign lane    = cnt_q[1:0] - 2'd1;   // lane of the byte arriving this cycle
    assign stall   = io_buffer_full && (mem_a[17:16] == IO_PREFIX);

    always_comb begin
        asm_word       = buf_q;
        asm_word[lane] = din_eff;
    end

    // next state and arbitration
    always_comb begin
        state_d  = state_q;
        grant    = FALSE;
        grant_if = FALSE;
        case (state_q)
            STATE_IDLE: begin
                if (!jump_wrong) begin
                    // on a tie, serve whoever did not win last time
                    if (bus.IF_valid_in && bus.LSB_valid_in)
                        grant_if = (last_grant == OWN_LSB);
                    else
                        grant_if = bus.IF_valid_in;
                    grant = bus.IF_valid_in || bus.LSB_valid_in;
                    if (grant)
                        state_d = (!grant_if && bus.LSB_wr_in) ? STATE_WRITE : STATE_READ;
                end
            end
            STATE_READ: begin
                if (jump_wrong)             state_d = STATE_IDLE;
                else if (cnt_q == req_q.len) state_d = STATE_DONE;
            end
            STATE_WRITE: begin
                if (!stall && cnt_q == req_q.len - 3'd1) state_d = STATE_DONE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STATE_IDLE;
            last_grant <= OWN_LSB;
            req_q      <= '0;
            cnt_q      <= 3'd0;
            buf_q      <= '0;
            mem_a      <= '0;
            mem_dout   <= 8'h00;
            if_data_q  <= ZERO32;
            lsb_data_q <= ZERO32;
        end else if (rdy) begin
            state_q <= state_d;
            case (state_q)
                STATE_IDLE: begin
                    if (grant) begin
                        last_grant <= grant_if ? OWN_IF : OWN_LSB;
                        cnt_q      <= 3'd0;
                        buf_q      <= '0;
                        if (grant_if) begin
                            req_q    <= '{owner: OWN_IF, len: 3'd4, data: ZERO32};
                            mem_a    <= bus.IF_addr_in;
                            mem_dout <= 8'h00;
                        end else begin
                            req_q    <= '{owner: OWN_LSB, len: size_len(bus.LSB_size_in),
                                          data: bus.LSB_data_in};
                            mem_a    <= bus.LSB_addr_in;
                            mem_dout <= bus.LSB_data_in[7:0];
                        end
                    end
                end
                STATE_READ: begin
                    // byte cycles 0..len-1 issue addresses; cycles 1..len collect
                    if (!jump_wrong) begin
                        if (cnt_q != 3'd0) buf_q <= asm_word;
                        if (cnt_q == req_q.len) begin
                            if (req_q.owner == OWN_IF) if_data_q  <= asm_word;
                            else                       lsb_data_q <= asm_word;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q + 3'd1 < req_q.len) mem_a <= mem_a + ADDR_W'(1);
                        end
                    end
                end
                STATE_WRITE: begin
                    // a stalled IO byte is simply presented again next cycle
                    if (!stall && cnt_q != req_q.len - 3'd1) begin
                        cnt_q    <= cnt_q + 3'd1;
                        mem_a    <= mem_a + ADDR_W'(1);
                        mem_dout <= req_q.data[cnt_q[1:0] + 2'd1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wr           = rdy && (state_q == STATE_WRITE) && !stall;
    assign bus.IF_done_out  = rdy && (state_q == STATE_DONE) && (req_q.owner == OWN_IF);
    assign bus.LSB_done_out = rdy && (state_q == STATE_DONE) && (req_q.owner == OWN_LSB);
    assign bus.IF_data_out  = if_data_q;
    assign bus.LSB_data_out = lsb_data_q;

endmodule
